// File: rtl/nn_stream_pkg.sv
// Shared types for the binarized feature-vector stream blocks.
package nn_stream_pkg;

   localparam int DATA_W_DEF = 256;

   typedef enum logic {
      BANK_FREE = 1'b0,
      BANK_FULL = 1'b1
   } bank_state_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } tx_state_t;

   // Index width for a counter over n positions; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// Address is {bank, ptr}; the array is sized to the full address space so a
// non-power-of-two frame length still decodes with a plain concatenation.
module frame_bank_ram #(
   parameter int DATA_W = 256,
   parameter int AW     = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << AW;

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port: store an accepted upstream word.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read port: one-cycle registered read, held when not enabled.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/bin_frame_tx.sv
// Ping-pong frame buffer that collects FRAME_LEN words from an upstream writer
// and replays each complete frame as an unbroken burst of FRAME_LEN valid cycles.
module bin_frame_tx
   import nn_stream_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int FRAME_LEN = 32,
   parameter int GAP       = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_vld,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_rdy,
   output logic              vld_out,
   output logic [DATA_W-1:0] data_out,
   output logic              sof_out,
   output logic              eof_out,
   output logic              busy
);

   localparam int PW = idx_w(FRAME_LEN);
   localparam int CW = idx_w(GAP);
   localparam int AW = PW + 1;
   localparam logic [PW-1:0] LAST     = PW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);

   bank_state_t       bank_st [2];
   logic              wr_bank, rd_bank;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   tx_state_t         state;
   logic [CW-1:0]     cnt;
   logic              wr_acc, wr_done, rd_en, rd_last;
   logic              vld_q, sof_q, eof_q;
   logic [DATA_W-1:0] ram_q;

   assign wr_rdy  = !rst && (bank_st[wr_bank] == BANK_FREE);
   assign wr_acc  = wr_vld && wr_rdy;
   assign wr_done = wr_acc && (wr_ptr == LAST);
   assign rd_en   = (state == ST_SEND);
   assign rd_last = rd_en && (rd_ptr == LAST);

   // Write side: fill the current bank, hand it over when its last word lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         wr_bank <= 1'b0;
      end else if (wr_acc) begin
         if (wr_ptr == LAST) begin
            wr_ptr  <= '0;
            wr_bank <= ~wr_bank;
         end else begin
            wr_ptr <= wr_ptr + 1'b1;
         end
      end
   end

   // Bank ownership: writer marks FULL, reader marks FREE. They never target the
   // same bank in one cycle because the writer is stalled while its bank is FULL.
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_st[0] <= BANK_FREE;
         bank_st[1] <= BANK_FREE;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (wr_done && (wr_bank == 1'(b)))      bank_st[b] <= BANK_FULL;
            else if (rd_last && (rd_bank == 1'(b))) bank_st[b] <= BANK_FREE;
         end
      end
   end

   // Read FSM: the end of a burst (or of the gap) looks straight at the next
   // bank so a waiting frame follows with no extra bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         rd_ptr  <= '0;
         rd_bank <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bank_st[rd_bank] == BANK_FULL) begin
                  state  <= ST_SEND;
                  rd_ptr <= '0;
               end
            end
            ST_SEND: begin
               if (rd_ptr == LAST) begin
                  rd_bank <= ~rd_bank;
                  rd_ptr  <= '0;
                  if (GAP > 0) begin
                     state <= ST_GAP;
                     cnt   <= GAP_LOAD;
                  end else if (bank_st[~rd_bank] == BANK_FULL) begin
                     state <= ST_SEND;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  rd_ptr <= rd_ptr + 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt == '0) begin
                  if (bank_st[rd_bank] == BANK_FULL) begin
                     state  <= ST_SEND;
                     rd_ptr <= '0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   frame_bank_ram #(
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr ({wr_bank, wr_ptr}),
      .wdata (wr_data),
      .re    (rd_en),
      .raddr ({rd_bank, rd_ptr}),
      .rdata (ram_q)
   );

   // Output flags track the RAM read latency so they line up with ram_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= 1'b0;
         sof_q <= 1'b0;
         eof_q <= 1'b0;
      end else begin
         vld_q <= rd_en;
         sof_q <= rd_en && (rd_ptr == '0);
         eof_q <= rd_last;
      end
   end

   assign vld_out  = vld_q;
   assign sof_out  = sof_q;
   assign eof_out  = eof_q;
   assign data_out = vld_q ? ram_q : '0;
   assign busy     = (bank_st[0] == BANK_FULL) || (bank_st[1] == BANK_FULL) || (state != ST_IDLE);

endmodule
